// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
// The control-output bundle is a packed struct so each pipeline situation
// is a named constant rather than six loose assignments.
package pipeline_ctrl_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    // RV32I major opcodes of the instruction classes that interact with stalls
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;

    // Per-stage enable/flush bundle
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_en;
        logic mem_wb_flush;
    } ctrl_t;

    // Held in reset: nothing advances, every stage register reads as NOP
    localparam ctrl_t CTRL_RST = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1,
                                   id_ex_flush: 1'b1, ex_mem_en: 1'b0, mem_wb_flush: 1'b1};
    // Normal flow
    localparam ctrl_t CTRL_RUN = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
                                   id_ex_flush: 1'b0, ex_mem_en: 1'b1, mem_wb_flush: 1'b0};
    // Memory wait: freeze everything upstream, bubble into WB
    localparam ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                                      id_ex_flush: 1'b0, ex_mem_en: 1'b0, mem_wb_flush: 1'b1};
    // Halted after a memory timeout
    localparam ctrl_t CTRL_HALT = CTRL_FREEZE;
    // Taken branch: redirect PC, squash the two younger instructions
    localparam ctrl_t CTRL_BRANCH = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1,
                                      id_ex_flush: 1'b1, ex_mem_en: 1'b1, mem_wb_flush: 1'b0};
    // Hazard: hold PC and IF/ID, inject a bubble into EX
    localparam ctrl_t CTRL_STALL = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                                     id_ex_flush: 1'b1, ex_mem_en: 1'b1, mem_wb_flush: 1'b0};

    // Branch beats hazard: the stalled instruction is squashed by the redirect anyway
    function automatic ctrl_t resolve(input logic branch_taken, input logic hazard);
        if (branch_taken)
            return CTRL_BRANCH;
        else if (hazard)
            return CTRL_STALL;
        else
            return CTRL_RUN;
    endfunction

endpackage

// File: rtl/pipe_perf_counter.sv
// Enable-gated free-running counter; wraps modulo 2^W.
module pipe_perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         en,
    output logic [W-1:0] cnt
);

    // Count one per enabled cycle, natural wrap
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            cnt <= '0;
        else if (en)
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Merges hazard stalls, EX branch redirects and multi-cycle data-memory
// handshakes into per-stage controls; a memory-wait timeout parks the core
// in HALT until reset.
// Optional: define PIPE_PERF_CNT_EN to build the stall/flush event counters;
// otherwise stall_cnt/flush_cnt read as zero and no counter flops exist.
module pipeline_stall_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             hazard,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(MEM_TIMEOUT);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_nxt;
    ctrl_t            ctrl, ctrl_out;

    // State and wait-counter registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Next state and same-cycle control decode
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        ctrl      = CTRL_RUN;
        unique case (state)
            RUN: begin
                if (dmem_req && !dmem_ack) begin
                    // Multi-cycle access starts; this is the first frozen cycle
                    ctrl      = CTRL_FREEZE;
                    state_nxt = MEM_WAIT;
                    wait_nxt  = CNT_W'(1);
                end else begin
                    ctrl     = resolve(branch_taken, hazard);
                    wait_nxt = '0;
                end
            end
            MEM_WAIT: begin
                if (dmem_ack) begin
                    // Stages were frozen, so pending hazard/branch are still valid here
                    ctrl      = resolve(branch_taken, hazard);
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end else begin
                    ctrl = CTRL_FREEZE;
                    if (wait_cnt == TIMEOUT_V)
                        state_nxt = HALT;
                    if (wait_cnt != '1)
                        wait_nxt = wait_cnt + CNT_W'(1);
                end
            end
            HALT: begin
                ctrl = CTRL_HALT;
            end
            default: begin
                ctrl      = CTRL_RST;
                state_nxt = RUN;
                wait_nxt  = '0;
            end
        endcase
    end

    // Reset overrides the decode immediately, without waiting for a clock
    always_comb begin
        ctrl_out = ctrl;
        if (!arst_n)
            ctrl_out = CTRL_RST;
    end

    assign pc_en        = ctrl_out.pc_en;
    assign if_id_en     = ctrl_out.if_id_en;
    assign if_id_flush  = ctrl_out.if_id_flush;
    assign id_ex_flush  = ctrl_out.id_ex_flush;
    assign ex_mem_en    = ctrl_out.ex_mem_en;
    assign mem_wb_flush = ctrl_out.mem_wb_flush;
    assign halted       = (state == HALT);

`ifdef PIPE_PERF_CNT_EN
    logic stall_evt, flush_evt;

    // Each pattern is unique to its case: only a hazard stall holds PC while
    // EX/MEM advances, and only a redirect writes PC while flushing IF/ID.
    assign stall_evt = !ctrl.pc_en && ctrl.ex_mem_en;
    assign flush_evt = ctrl.pc_en && ctrl.if_id_flush;

    pipe_perf_counter #(.W(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .en     (stall_evt),
        .cnt    (stall_cnt)
    );

    pipe_perf_counter #(.W(CNT_W)) u_flush_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .en     (flush_evt),
        .cnt    (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl (MEM_TIMEOUT=4, CNT_W=16).
// Stimulus pushes the hand-derived expected outputs for each cycle; the
// monitor pops and compares mid-cycle on the falling edge.
module tb_pipeline_stall_ctrl;

    localparam int CNT_W = 16;

`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_flush, halted}
    localparam logic [6:0] E_RUN = 7'b1100100;
    localparam logic [6:0] E_STL = 7'b0001100;
    localparam logic [6:0] E_BR  = 7'b1111100;
    localparam logic [6:0] E_FRZ = 7'b0000010;
    localparam logic [6:0] E_HLT = 7'b0000011;
    localparam logic [6:0] E_RST = 7'b0011010;

    typedef struct {
        string            nm;
        logic [6:0]       ctl;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    logic hazard = 1'b0, branch_taken = 1'b0, dmem_req = 1'b0, dmem_ack = 1'b0;
    logic pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_flush, halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    exp_t             q[$];
    int               checks = 0;
    int               failures = 0;
    logic [CNT_W-1:0] es = '0;
    logic [CNT_W-1:0] ef = '0;

    pipeline_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .hazard       (hazard),
        .branch_taken (branch_taken),
        .dmem_req     (dmem_req),
        .dmem_ack     (dmem_ack),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_en    (ex_mem_en),
        .mem_wb_flush (mem_wb_flush),
        .halted       (halted),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus plus its expected outputs
    task automatic step(input logic h, input logic b, input logic rq, input logic ak,
                        input logic [6:0] ectl, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        hazard = h; branch_taken = b; dmem_req = rq; dmem_ack = ak;
        e.nm = nm; e.ctl = ectl; e.sc = es; e.fc = ef;
        q.push_back(e);
        // Counters are registered: the event shows up from the next cycle on
        if (PERF && ectl == E_STL) es = es + 1'b1;
        if (PERF && ectl == E_BR)  ef = ef + 1'b1;
    endtask

    // Assert reset mid-cycle, check outputs before any clock edge, release
    task automatic reset_pulse(input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        arst_n = 1'b0;
        hazard = 1'b0; branch_taken = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
        es = '0; ef = '0;
        e.nm = nm; e.ctl = E_RST; e.sc = '0; e.fc = '0;
        q.push_back(e);
        @(posedge clk);
        #1;
        arst_n = 1'b1;
    endtask

    // Monitor: compare DUT against the oldest pending expectation
    initial begin
        exp_t e;
        logic [6:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                act = {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_flush, halted};
                checks++;
                if (act !== e.ctl || stall_cnt !== e.sc || flush_cnt !== e.fc) begin
                    failures++;
                    $display("FAIL %s: got ctl=%b stall=%0d flush=%0d, want ctl=%b stall=%0d flush=%0d",
                             e.nm, act, stall_cnt, flush_cnt, e.ctl, e.sc, e.fc);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, pending=%0d", q.size());
        $fatal(1, "timeout");
    end

    initial begin
        reset_pulse("reset_state");
        step(0, 0, 0, 0, E_RUN, "idle");
        // Single-cycle hazard
        step(1, 0, 0, 0, E_STL, "hazard");
        step(0, 0, 0, 0, E_RUN, "after_hazard");

        // Hazard and branch together: branch wins
        reset_pulse("reset_2");
        step(1, 1, 0, 0, E_BR,  "hazard_branch");
        step(0, 0, 0, 0, E_RUN, "after_branch");

        // Zero-wait access
        step(0, 0, 1, 1, E_RUN, "zero_wait");
        step(0, 0, 0, 0, E_RUN, "after_zero_wait");

        // Ack after 3 frozen cycles
        step(0, 0, 1, 0, E_FRZ, "mw_enter");
        step(0, 0, 1, 0, E_FRZ, "mw_wait1");
        step(0, 0, 1, 0, E_FRZ, "mw_wait2");
        step(0, 0, 1, 1, E_RUN, "mw_ack");
        step(0, 0, 0, 0, E_RUN, "mw_post");

        // Branch held through a wait: flush only on the ack cycle
        step(0, 1, 1, 0, E_FRZ, "bw_enter");
        step(0, 1, 1, 0, E_FRZ, "bw_wait");
        step(0, 1, 1, 1, E_BR,  "bw_ack");
        step(0, 0, 0, 0, E_RUN, "bw_post");

        // Hazard held through a wait: stall applied on the ack cycle
        step(1, 0, 1, 0, E_FRZ, "hw_enter");
        step(1, 0, 1, 1, E_STL, "hw_ack");
        step(0, 0, 0, 0, E_RUN, "hw_post");

        // Ack arriving exactly at the timeout count still returns to RUN
        step(0, 0, 1, 0, E_FRZ, "edge_enter");
        step(0, 0, 1, 0, E_FRZ, "edge_w1");
        step(0, 0, 1, 0, E_FRZ, "edge_w2");
        step(0, 0, 1, 0, E_FRZ, "edge_w3");
        step(0, 0, 1, 1, E_RUN, "edge_ack_at_limit");

        // Reset in the middle of a wait (counter at 2)
        step(0, 0, 1, 0, E_FRZ, "rw_enter");
        step(0, 0, 1, 0, E_FRZ, "rw_wait1");
        reset_pulse("reset_mid_wait");
        step(1, 0, 0, 0, E_STL, "post_reset_in_run");
        step(0, 0, 0, 0, E_RUN, "post_reset_idle");

        // Timeout: 4 wait cycles without ack then HALT
        step(0, 0, 1, 0, E_FRZ, "to_enter");
        step(0, 0, 1, 0, E_FRZ, "to_w1");
        step(0, 0, 1, 0, E_FRZ, "to_w2");
        step(0, 0, 1, 0, E_FRZ, "to_w3");
        step(0, 0, 1, 0, E_FRZ, "to_w4");
        step(0, 1, 1, 1, E_HLT, "halt_branch_ack");
        step(1, 0, 0, 0, E_HLT, "halt_hazard");
        step(0, 0, 0, 0, E_HLT, "halt_idle");

        // Only reset leaves HALT
        reset_pulse("reset_from_halt");
        step(0, 0, 0, 0, E_RUN, "run_after_halt");

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending expectations got %0d, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
